// File: rtl/riscv_pkg.sv
// Types and constants shared by the RV32I pipeline stages.
package riscv_pkg;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Field order makes {inst, pc} line up with the 64-bit fetch/decode register.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO that holds fetched {inst, pc} packets until decode takes them.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  fetch_pkt_t    push_data,
    input  logic          pop,
    output fetch_pkt_t    pop_data,
    input  logic          flush,
    output logic [CW-1:0] count
);

    fetch_pkt_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight and
// buffers returned words for decode. Redirects flush everything and drop stale responses.
//
//   state   | meaning
//   ST_IDLE | no request; waiting for buffer room
//   ST_REQ  | imem_req high, imem_addr held until granted
//   ST_WAIT | granted, waiting for imem_rvalid
module fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [63:0] fetch_dec_reg,
    output logic        fetch_valid
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t   state_q, state_d;
    logic [31:0]    pc_q, pc_d;
    logic [31:0]    addr_q, addr_d;
    logic           drop_q, drop_d;
    logic           req_q, req_d;
    fetch_pkt_t     out_q, out_d;
    logic           valid_q, valid_d;

    logic           push, pop;
    fetch_pkt_t     push_pkt, pop_pkt;
    logic [CW-1:0]  count, next_count;
    logic [31:0]    redir_pc;
    logic           rsp_here, gnt_here, room;

    assign redir_pc   = redirect_pc & 32'hFFFF_FFFC;
    assign rsp_here   = (state_q == ST_WAIT) && imem_rvalid;
    assign gnt_here   = (state_q == ST_REQ) && imem_gnt;
    assign push       = rsp_here && !drop_q && !redirect_en;
    assign pop        = !redirect_en && !stall && (count != '0);
    assign push_pkt   = '{inst: imem_rdata, pc: addr_q};
    assign next_count = redirect_en ? '0 : count + CW'(push) - CW'(pop);
    assign room       = next_count < CW'(FIFO_DEPTH);

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push),
        .push_data (push_pkt),
        .pop       (pop),
        .pop_data  (pop_pkt),
        .flush     (redirect_en),
        .count     (count)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        drop_d  = drop_q;

        // A granted request that was already dropped must not advance the redirected PC.
        if (redirect_en)               pc_d = redir_pc;
        else if (gnt_here && !drop_q)  pc_d = addr_q + 32'd4;

        unique case (state_q)
            ST_IDLE: begin
                if (room) begin
                    state_d = ST_REQ;
                    addr_d  = pc_d;
                end
            end
            ST_REQ: begin
                if (imem_gnt)    state_d = ST_WAIT;
                if (redirect_en) drop_d  = 1'b1;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    drop_d = 1'b0;
                    if (room) begin
                        state_d = ST_REQ;
                        addr_d  = pc_d;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (redirect_en) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_d = (state_d == ST_REQ);

        out_d   = out_q;
        valid_d = valid_q;
        if (redirect_en) begin
            out_d   = '{inst: NOP_INST, pc: redir_pc};
            valid_d = 1'b0;
        end else if (!stall) begin
            if (count != '0) begin
                out_d   = pop_pkt;
                valid_d = 1'b1;
            end else begin
                out_d   = '{inst: NOP_INST, pc: out_q.pc};
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            drop_q  <= 1'b0;
            req_q   <= 1'b0;
            out_q   <= '{inst: NOP_INST, pc: RESET_PC};
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
            req_q   <= req_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req      = req_q;
    assign imem_addr     = addr_q;
    assign fetch_dec_reg = out_q;
    assign fetch_valid   = valid_q;

endmodule
